// File: rtl/wb_stage_pkg.sv
// Writeback-stage shared definitions: opcode/funct constants, link register, select enums.
// Pure declarations; no latency. No backpressure.
// Sub-word load types are only decoded when WB_LOAD_EXT_EN is defined.
package wb_stage_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_SLTI    = 6'h0a;
    localparam logic [5:0] OP_ANDI    = 6'h0c;
    localparam logic [5:0] OP_ORI     = 6'h0d;
    localparam logic [5:0] OP_XORI    = 6'h0e;
    localparam logic [5:0] OP_LUI     = 6'h0f;
    localparam logic [5:0] OP_LB      = 6'h20;
    localparam logic [5:0] OP_LH      = 6'h21;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_LBU     = 6'h24;
    localparam logic [5:0] OP_LHU     = 6'h25;

    localparam logic [5:0] F_SLL  = 6'h00;
    localparam logic [5:0] F_SRL  = 6'h02;
    localparam logic [5:0] F_SRA  = 6'h03;
    localparam logic [5:0] F_SLLV = 6'h04;
    localparam logic [5:0] F_SRLV = 6'h06;
    localparam logic [5:0] F_SRAV = 6'h07;
    localparam logic [5:0] F_JALR = 6'h09;
    localparam logic [5:0] F_ADD  = 6'h20;
    localparam logic [5:0] F_ADDU = 6'h21;
    localparam logic [5:0] F_SUB  = 6'h22;
    localparam logic [5:0] F_SUBU = 6'h23;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_XOR  = 6'h26;
    localparam logic [5:0] F_NOR  = 6'h27;
    localparam logic [5:0] F_SLT  = 6'h2a;
    localparam logic [5:0] F_SLTU = 6'h2b;

    localparam int RA_LINK = 31;

    typedef enum logic [1:0] {WB_NONE, WB_ALU, WB_MEM, WB_PC8} wb_sel_e;
    typedef enum logic [2:0] {LD_W, LD_B, LD_BU, LD_H, LD_HU} ld_type_e;

    // SPECIAL-opcode functs that produce an ALU result into rd (jr/jalr/mult excluded)
    function automatic logic is_rtype_alu(input logic [5:0] funct);
        case (funct)
            F_SLL, F_SRL, F_SRA, F_SLLV, F_SRLV, F_SRAV,
            F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND, F_OR,
            F_XOR, F_NOR, F_SLT, F_SLTU: return 1'b1;
            default:                     return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/wb_stage_if.sv
// M-to-W pipeline bus plus register-file write port and W-stage status.
// No logic; latency set by wb_stage. stall_i/flush_i travel with the bus.
// slave = writeback stage, master = surrounding pipeline.
interface wb_stage_if #(
    parameter int DATA_W = 32,
    parameter int RA_W   = 5,
    parameter int CNT_W  = 32
);
    logic              stall_i;
    logic              flush_i;
    logic              in_valid;
    logic [31:0]       ir_m;
    logic [DATA_W-1:0] pc8_m;
    logic [DATA_W-1:0] ao_m;
    logic [DATA_W-1:0] dr_m;
    logic              rf_we;
    logic [RA_W-1:0]   rf_a3;
    logic [DATA_W-1:0] rf_wd;
    logic [31:0]       ir_w;
    logic              valid_w;
    logic [CNT_W-1:0]  instret;

    modport master (
        output stall_i, flush_i, in_valid, ir_m, pc8_m, ao_m, dr_m,
        input  rf_we, rf_a3, rf_wd, ir_w, valid_w, instret
    );

    modport slave (
        input  stall_i, flush_i, in_valid, ir_m, pc8_m, ao_m, dr_m,
        output rf_we, rf_a3, rf_wd, ir_w, valid_w, instret
    );
endinterface

// File: rtl/wb_stage_load_ext.sv
// Load data aligner/extender: picks byte/half from the raw memory word and extends it.
// Purely combinational. No backpressure.
// Only instantiated when WB_LOAD_EXT_EN is defined.
module wb_stage_load_ext
    import wb_stage_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] dr,
    input  logic [1:0]        ofs,
    input  ld_type_e          ld_type,
    output logic [DATA_W-1:0] wd
);
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = dr[7:0];
        case (ofs)
            2'd0: byte_v = dr[7:0];
            2'd1: byte_v = dr[15:8];
            2'd2: byte_v = dr[23:16];
            2'd3: byte_v = dr[31:24];
            default: byte_v = dr[7:0];
        endcase
        // Halfword ignores ofs[0]: misalignment is trapped elsewhere, not here
        half_v = ofs[1] ? dr[31:16] : dr[15:0];
    end

    always_comb begin
        wd = DATA_W'($signed(dr[31:0]));
        case (ld_type)
            LD_B:    wd = DATA_W'($signed(byte_v));
            LD_BU:   wd = DATA_W'(byte_v);
            LD_H:    wd = DATA_W'($signed(half_v));
            LD_HU:   wd = DATA_W'(half_v);
            default: wd = DATA_W'($signed(dr[31:0]));
        endcase
    end
endmodule

// File: rtl/wb_stage.sv
// Writeback stage: W pipeline register, writeback decode, retired-instruction counter.
// One cycle M inputs -> rf_* (rf_* combinational from W register). stall_i holds W, flush_i bubbles it.
// Macro WB_LOAD_EXT_EN enables lb/lbu/lh/lhu writeback; otherwise only lw loads write.
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int RA_W   = 5,
    parameter int CNT_W  = 32
) (
    input  logic      clk,
    input  logic      reset,
    wb_stage_if.slave bus
);
    logic              valid_q;
    logic [31:0]       ir_q;
    logic [DATA_W-1:0] pc8_q;
    logic [DATA_W-1:0] ao_q;
    logic [DATA_W-1:0] dr_q;
    logic [CNT_W-1:0]  instret_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q   <= 1'b0;
            ir_q      <= '0;
            pc8_q     <= '0;
            ao_q      <= '0;
            dr_q      <= '0;
            instret_q <= '0;
        end else begin
            if (bus.flush_i) begin
                valid_q <= 1'b0;
            end else if (!bus.stall_i) begin
                valid_q <= bus.in_valid;
                ir_q    <= bus.ir_m;
                pc8_q   <= bus.pc8_m;
                ao_q    <= bus.ao_m;
                dr_q    <= bus.dr_m;
            end
            // An instruction retires only when it actually leaves W
            if (valid_q && !bus.stall_i && !bus.flush_i)
                instret_q <= instret_q + CNT_W'(1);
        end
    end

    logic [5:0]        opcode;
    logic [5:0]        funct;
    logic [RA_W-1:0]   rt;
    logic [RA_W-1:0]   rd;
    wb_sel_e           wb_sel;
    logic [RA_W-1:0]   dst;
    logic [DATA_W-1:0] mem_wd;
    logic [DATA_W-1:0] wd;
    logic              we;

    assign opcode = ir_q[31:26];
    assign funct  = ir_q[5:0];
    assign rt     = RA_W'(ir_q[20:16]);
    assign rd     = RA_W'(ir_q[15:11]);

`ifdef WB_LOAD_EXT_EN
    ld_type_e ld_type;
`endif

    always_comb begin
        wb_sel = WB_NONE;
        dst    = '0;
`ifdef WB_LOAD_EXT_EN
        ld_type = LD_W;
`endif
        case (opcode)
            OP_SPECIAL: begin
                if (funct == F_JALR) begin
                    wb_sel = WB_PC8;
                    dst    = rd;
                end else if (is_rtype_alu(funct)) begin
                    wb_sel = WB_ALU;
                    dst    = rd;
                end
            end
            OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
                wb_sel = WB_ALU;
                dst    = rt;
            end
            OP_JAL: begin
                wb_sel = WB_PC8;
                dst    = RA_W'(RA_LINK);
            end
            OP_LW: begin
                wb_sel = WB_MEM;
                dst    = rt;
            end
`ifdef WB_LOAD_EXT_EN
            OP_LB:  begin wb_sel = WB_MEM; dst = rt; ld_type = LD_B;  end
            OP_LBU: begin wb_sel = WB_MEM; dst = rt; ld_type = LD_BU; end
            OP_LH:  begin wb_sel = WB_MEM; dst = rt; ld_type = LD_H;  end
            OP_LHU: begin wb_sel = WB_MEM; dst = rt; ld_type = LD_HU; end
`endif
            default: ;
        endcase
    end

`ifdef WB_LOAD_EXT_EN
    wb_stage_load_ext #(.DATA_W(DATA_W)) load_ext (
        .dr      (dr_q),
        .ofs     (ao_q[1:0]),
        .ld_type (ld_type),
        .wd      (mem_wd)
    );
`else
    assign mem_wd = DATA_W'($signed(dr_q[31:0]));
`endif

    always_comb begin
        wd = '0;
        case (wb_sel)
            WB_ALU:  wd = ao_q;
            WB_MEM:  wd = mem_wd;
            WB_PC8:  wd = pc8_q;
            default: wd = '0;
        endcase
    end

    assign we = valid_q && (wb_sel != WB_NONE) && (dst != '0);

    assign bus.rf_we   = we;
    assign bus.rf_a3   = we ? dst : '0;
    assign bus.rf_wd   = we ? wd  : '0;
    assign bus.ir_w    = ir_q;
    assign bus.valid_w = valid_q;
    assign bus.instret = instret_q;
endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32, datapath width of PC8/AO/DR/write data (legal 32 or 64).
REQ-002 SHALL have parameter RA_W, default 5, register-file address width.
REQ-003 SHALL have parameter CNT_W, default 32, retired-instruction counter width.
REQ-004 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have ports stall_i / flush_i  in  1 / 1  hold / bubble the W register.
REQ-007 SHALL have port in_valid  in  1  M-stage instruction valid.
REQ-008 SHALL have ports ir_m  in  32, pc8_m / ao_m / dr_m  in  DATA_W  instruction, PC+8, ALU result, raw memory word.
REQ-009 SHALL have ports rf_we  out  1, rf_a3  out  RA_W, rf_wd  out  DATA_W  register-file write port.
REQ-010 SHALL have ports ir_w  out  32, valid_w  out  1  W-stage instruction for the hazard unit.
REQ-011 SHALL have port instret  out  CNT_W  retired-instruction count.

Function
REQ-012 W register (valid, ir, pc8, ao, dr) SHALL update on clk edge with priority reset > flush_i (valid<=0) > stall_i (hold all) > capture in_valid and M inputs.
REQ-013 Latency SHALL be exactly one cycle from M inputs to rf_* outputs; rf_* SHALL be combinational from the W register only.
REQ-014 Decode SHALL select writeback: R-type ALU -> a3=rd, wd=ao; I-type ALU (addiu, ori, lui, slti, andi, xori) -> a3=rt, wd=ao; loads -> a3=rt, wd=extended dr; jal -> a3=31, wd=pc8; jalr -> a3=rd, wd=pc8; all others rf_we=0.
REQ-015 rf_we SHALL be 0 when valid_w=0, when a3=0, or when instruction does not write.
REQ-016 rf_a3 and rf_wd SHALL be 0 whenever rf_we=0.
REQ-017 Load extension SHALL use ao[1:0] as byte offset: lb/lbu select byte ao[1:0], lh/lhu select half ao[1], sign or zero extended to DATA_W; lw passes dr[31:0] (sign-extended when DATA_W=64).
REQ-018 Misaligned lh/lhu (ao[0]=1) SHALL use ao[1] only, ignoring ao[0]; no exception raised here.
REQ-019 instret SHALL increment by 1 on every edge where valid_w=1 and stall_i=0 and flush_i=0, wrapping from 2^CNT_W-1 to 0.
REQ-020 Simultaneous stall_i and flush_i SHALL behave as flush (valid<=0), and the retiring instruction SHALL NOT be counted.

Reset
REQ-021 reset SHALL clear valid_w, ir_w, pc8, ao, dr and instret to 0 on the next edge; rf_we=0, rf_a3=0, rf_wd=0 thereafter.
REQ-022 reset asserted mid-stall SHALL override stall_i; no register holds its value.

Configuration
REQ-023 Macro WB_LOAD_EXT_EN SHALL gate sub-word loads: defined -> lb/lbu/lh/lhu decoded per REQ-017; undefined -> only lw writes back, sub-word loads give rf_we=0.

Structure
REQ-024 Shared package SHALL hold opcode/funct constants, RA_LINK=31, and the writeback-select enum (WB_NONE, WB_ALU, WB_MEM, WB_PC8).
REQ-025 Sub-module load_ext SHALL implement REQ-017 (inputs dr, ao[1:0], load type; output DATA_W word), instantiated only under WB_LOAD_EXT_EN.

Verification
REQ-026 addu $3 (ir=0x00221821), ao=0x12345678, in_valid=1 -> next cycle rf_we=1, rf_a3=3, rf_wd=0x12345678, instret=1 one edge later.
REQ-027 lb rt=5, dr=0x80FF7F01, ao[1:0]=2 -> rf_wd=0xFFFFFFFF; lbu same -> 0x000000FF; lh ao[1]=1 -> 0xFFFF80FF.
REQ-028 jal, pc8_m=0x00003008 -> rf_a3=31, rf_wd=0x00003008; addu to $0 -> rf_we=0, rf_a3=0, rf_wd=0.
REQ-029 stall_i=1 for 3 cycles with changing M inputs -> rf_* constant, instret unchanged; stall_i+flush_i same cycle -> valid_w=0 next cycle.
REQ-030 CNT_W=4, 17 retirements -> instret=1; reset during stream -> all outputs 0 next cycle.
REQ-031 Build without WB_LOAD_EXT_EN, lb issued -> rf_we=0; lw -> rf_wd=dr.
